fp_stage2_align: RTL and testbench
==================================

// Module: fp_stage2_align
// PURPOSE
//  Stage 2 of the 4-stage single-precision add/sub pipeline, directly after stage-1 compare.
//  - Orders the operands so the big operand's magnitude is >= the small operand's.
//  - Right-shifts the small mantissa by the corrected exponent difference into a 27-bit
//    {man, G, R, S} field.
//  - Flags IEEE special cases (NaN, Inf) for stage 3 (add/normalise).
//  - Registered, valid/ready handshake, 1-cycle latency.
// PARAMETERS
//  EXP_W  8   exponent width
//  MAN_W  24  mantissa width incl. hidden bit
//  GRS_W  3   guard/round/sticky bits appended to the aligned small mantissa
// PORTS
//  clk           in   1      clock
//  rst           in   1      asynchronous, active-high reset
//  flush         in   1      synchronous pipeline flush
//  in_valid      in   1      stage-1 outputs valid this cycle
//  in_ready      out  1      stage 2 can accept: !out_valid || out_ready
//  A_sign        in   1      stage-1 A sign
//  B_sign_eff    in   1      stage-1 B sign with the subtract op folded in
//  A_exp,B_exp   in   8      raw biased exponents
//  A_man,B_man   in   24     mantissas, hidden bit already resolved (0 for denormal)
//  exp_diff      in   8      |A_exp - B_exp| on raw exponents
//  A_bigger      in   1      A_exp >= B_exp
//  out_valid     out  1      outputs below valid
//  out_ready     in   1      stage 3 accepts
//  big_sign      out  1      sign of the larger-magnitude operand
//  eff_sub       out  1      big_sign ^ small_sign
//  res_exp       out  8      big operand exponent; 1 if the big operand is denormal
//  big_man       out  24     big mantissa, unshifted
//  small_aln     out  27     aligned small mantissa {man[23:0], G, R, S}
//  spec_valid    out  1      special case; spec_result overrides the stage-3 sum
//  spec_result   out  32     canonical special result
// BEHAVIOUR
//  Reset: out_valid=0; all data outputs 0.
//  Handshake:
//  - Capture when in_valid && in_ready.
//  - out_valid && !out_ready: every output holds stable; in_ready=0.
//  - out_ready && !in_valid: out_valid falls next cycle.
//  - flush=1: out_valid<=0 next cycle and the concurrent input is dropped; flush wins over capture.
//  Operand order:
//  - exp_diff!=0: big = A if A_bigger, else big = B.
//  - exp_diff==0: big = A if A_man >= B_man, else big = B. Equal magnitudes -> A is big.
//  - big_sign/small_sign come from A_sign/B_sign_eff according to the chosen order.
//  Denormal correction:
//  - Effective exponent of exp==0 is 1.
//  - shift = exp_diff - 1 when small_exp==0 && big_exp!=0; otherwise shift = exp_diff.
//  - res_exp = (big_exp==0) ? 1 : big_exp.
//  Alignment (no wrap-around):
//  - sat = min(shift,27); w[50:0] = {small_man,27'b0} >> sat.
//  - small_aln = {w[50:25], |w[24:0]}.
//  - shift>=27 gives small_aln = {26'b0, |small_man}.
//  Specials (exp==8'hFF; frac = man[22:0]):
//  - Any NaN, or Inf-Inf with eff_sub=1: spec_valid=1, spec_result=32'h7FC00000.
//  - Otherwise any Inf: spec_valid=1, spec_result={inf_sign,8'hFF,23'b0}.
//    inf_sign = A_sign if A is Inf, else B_sign_eff.
//  - Otherwise spec_valid=0, spec_result=0.
//  - Data outputs are still computed when spec_valid=1; stage 3 ignores them.
//  Zero operands are not special here; they align as normal mantissas of 0.
// STRUCTURE
//  Package fp_pkg:
//  - EXP_W, MAN_W, GRS_W, EXP_MAX=8'hFF, QNAN=32'h7FC00000.
//  - typedef stage2_t = {big_sign, eff_sub, res_exp, big_man, small_aln, spec_valid, spec_result}.
//  Sub-module fp_align_shift: combinational saturating sticky right shifter (man, shift -> aln).
//  Top level holds the swap/special logic and the output register with handshake.
// TESTING
//  1. A=B=1.0: exps 127/127, mans 800000/800000, diff=0, A_bigger=1
//     -> big_man=800000, small_aln=27'h4000000, res_exp=127, eff_sub=0, one cycle after capture.
//  2. Equal exps, A_man=800000, B_man=C00000, A_bigger=1 -> swap: big_man=C00000, big_sign=B_sign_eff.
//  3. diff=30, small_man=800000 -> small_aln=27'h0000001; diff=255 gives the same result.
//  4. A_exp=1, A_man=800000; B_exp=0, B_man=400000; diff=1
//     -> shift 0, small_aln=27'h2000000, res_exp=1.
//  5. A=+Inf, B_sign_eff flips B=+Inf into eff_sub=1 -> spec_valid=1, spec_result=7FC00000.
//     A=+Inf, B=1.0 -> spec_result=7F800000.
//  6. Backpressure and reset:
//     - out_ready=0 for 3 cycles with in_valid=1: outputs frozen, in_ready=0, no input lost.
//     - rst pulse mid-hold -> out_valid=0 immediately.
//     - flush and in_valid in the same cycle -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths, constants and the stage-2 payload for the single-precision add/sub pipeline.
package fp_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 24;
    localparam int unsigned GRS_W = 3;
    localparam int unsigned ALN_W = MAN_W + GRS_W;
    localparam int unsigned SHF_W = 5;
    localparam int unsigned FP_W  = 32;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [FP_W-1:0]  QNAN    = 32'h7FC0_0000;

    typedef struct packed {
        logic             big_sign;
        logic             eff_sub;
        logic [EXP_W-1:0] res_exp;
        logic [MAN_W-1:0] big_man;
        logic [ALN_W-1:0] small_aln;
        logic             spec_valid;
        logic [FP_W-1:0]  spec_result;
    } stage2_t;

endpackage

// File: rtl/fp_align_shift.sv
// Saturating right shifter producing {man, G, R, S}; everything shifted past R folds into sticky.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] man,
    input  logic [EXP_W-1:0] shift,
    output logic [ALN_W-1:0] aln
);

    localparam int unsigned     W_W     = MAN_W + ALN_W;
    localparam logic [EXP_W-1:0] SAT_MAX = EXP_W'(ALN_W);

    logic [SHF_W-1:0] sat;
    logic [W_W-1:0]   w;

    always_comb begin
        sat = (shift > SAT_MAX) ? SHF_W'(ALN_W) : shift[SHF_W-1:0];
        w   = {man, {ALN_W{1'b0}}} >> sat;
        aln = {w[W_W-1 -: ALN_W-1], |w[MAN_W:0]};
    end

endmodule

// File: rtl/fp_stage2_align.sv
// Add/sub stage 2: operand swap, denormal-corrected alignment, special detection, output register.
module fp_stage2_align
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             A_sign,
    input  logic             B_sign_eff,
    input  logic [EXP_W-1:0] A_exp,
    input  logic [EXP_W-1:0] B_exp,
    input  logic [MAN_W-1:0] A_man,
    input  logic [MAN_W-1:0] B_man,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic             A_bigger,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             big_sign,
    output logic             eff_sub,
    output logic [EXP_W-1:0] res_exp,
    output logic [MAN_W-1:0] big_man,
    output logic [ALN_W-1:0] small_aln,
    output logic             spec_valid,
    output logic [FP_W-1:0]  spec_result
);

    logic             a_big;
    logic             small_sign;
    logic [EXP_W-1:0] big_exp;
    logic [EXP_W-1:0] small_exp;
    logic [MAN_W-1:0] small_man;
    logic [EXP_W-1:0] shift;
    logic [ALN_W-1:0] aln;
    logic             a_nan, b_nan, a_inf, b_inf;
    stage2_t          nxt;
    stage2_t          data_d, data_q;
    logic             valid_d, valid_q;

    fp_align_shift u_shift (
        .man   (small_man),
        .shift (shift),
        .aln   (aln)
    );

    // Swap so big >= small in magnitude; equal magnitudes keep A as big.
    always_comb begin
        a_big      = (exp_diff != '0) ? A_bigger : (A_man >= B_man);
        big_exp    = a_big ? A_exp : B_exp;
        small_exp  = a_big ? B_exp : A_exp;
        small_man  = a_big ? B_man : A_man;
        small_sign = a_big ? B_sign_eff : A_sign;

        // A denormal small operand already sits one binade higher than its raw exponent.
        shift = exp_diff;
        if (small_exp == '0 && big_exp != '0 && exp_diff != '0) begin
            shift = exp_diff - EXP_W'(1);
        end

        a_nan = (A_exp == EXP_MAX) && (A_man[MAN_W-2:0] != '0);
        b_nan = (B_exp == EXP_MAX) && (B_man[MAN_W-2:0] != '0);
        a_inf = (A_exp == EXP_MAX) && (A_man[MAN_W-2:0] == '0);
        b_inf = (B_exp == EXP_MAX) && (B_man[MAN_W-2:0] == '0);

        nxt.big_sign  = a_big ? A_sign : B_sign_eff;
        nxt.eff_sub   = nxt.big_sign ^ small_sign;
        nxt.res_exp   = (big_exp == '0) ? EXP_W'(1) : big_exp;
        nxt.big_man   = a_big ? A_man : B_man;
        nxt.small_aln = aln;

        nxt.spec_valid  = 1'b0;
        nxt.spec_result = '0;
        if (a_nan || b_nan || (a_inf && b_inf && nxt.eff_sub)) begin
            nxt.spec_valid  = 1'b1;
            nxt.spec_result = QNAN;
        end else if (a_inf || b_inf) begin
            nxt.spec_valid  = 1'b1;
            nxt.spec_result = {(a_inf ? A_sign : B_sign_eff), EXP_MAX, {(MAN_W-1){1'b0}}};
        end
    end

    assign in_ready = !valid_q || out_ready;

    // Output register; flush outranks capture.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid   = valid_q;
    assign big_sign    = data_q.big_sign;
    assign eff_sub     = data_q.eff_sub;
    assign res_exp     = data_q.res_exp;
    assign big_man     = data_q.big_man;
    assign small_aln   = data_q.small_aln;
    assign spec_valid  = data_q.spec_valid;
    assign spec_result = data_q.spec_result;

endmodule

// File: tb/tb_fp_stage2_align.sv
// Vector table plus scoreboard bench for fp_stage2_align, with handshake/reset/flush sequences.
module tb_fp_stage2_align;
    import fp_pkg::*;

    typedef struct {
        logic        a_sign;
        logic        b_sign;
        logic [7:0]  a_exp;
        logic [7:0]  b_exp;
        logic [23:0] a_man;
        logic [23:0] b_man;
        logic [7:0]  diff;
        logic        a_bigger;
        stage2_t     res;
    } vec_t;

    localparam int NV = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        a_sign = 1'b0, b_sign = 1'b0;
    logic [7:0]  a_exp = '0, b_exp = '0, diff = '0;
    logic [23:0] a_man = '0, b_man = '0;
    logic        a_bigger = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        big_sign, eff_sub, spec_valid;
    logic [7:0]  res_exp;
    logic [23:0] big_man;
    logic [26:0] small_aln;
    logic [31:0] spec_result;

    int      checks = 0;
    int      failures = 0;
    vec_t    vecs [NV];
    stage2_t exp_cur;
    stage2_t sb [$];

    always #5 clk = ~clk;

    fp_stage2_align dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A_sign(a_sign), .B_sign_eff(b_sign), .A_exp(a_exp), .B_exp(b_exp),
        .A_man(a_man), .B_man(b_man), .exp_diff(diff), .A_bigger(a_bigger),
        .out_valid(out_valid), .out_ready(out_ready), .big_sign(big_sign), .eff_sub(eff_sub),
        .res_exp(res_exp), .big_man(big_man), .small_aln(small_aln),
        .spec_valid(spec_valid), .spec_result(spec_result)
    );

    function automatic vec_t mk(logic as, logic bs, logic [7:0] ae, logic [7:0] be,
                                logic [23:0] am, logic [23:0] bm, logic [7:0] d, logic ab,
                                logic ebs, logic ees, logic [7:0] ere, logic [23:0] ebm,
                                logic [26:0] eal, logic esv, logic [31:0] esr);
        vec_t v;
        v.a_sign = as; v.b_sign = bs; v.a_exp = ae; v.b_exp = be;
        v.a_man = am; v.b_man = bm; v.diff = d; v.a_bigger = ab;
        v.res.big_sign = ebs; v.res.eff_sub = ees; v.res.res_exp = ere;
        v.res.big_man = ebm; v.res.small_aln = eal;
        v.res.spec_valid = esv; v.res.spec_result = esr;
        return v;
    endfunction

    function automatic stage2_t actual();
        stage2_t a;
        a.big_sign = big_sign; a.eff_sub = eff_sub; a.res_exp = res_exp;
        a.big_man = big_man; a.small_aln = small_aln;
        a.spec_valid = spec_valid; a.spec_result = spec_result;
        return a;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic check_data(input string name, input stage2_t act, input stage2_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got sgn=%b sub=%b exp=%h man=%h aln=%h sv=%b sr=%h expected sgn=%b sub=%b exp=%h man=%h aln=%h sv=%b sr=%h",
                     name, act.big_sign, act.eff_sub, act.res_exp, act.big_man, act.small_aln,
                     act.spec_valid, act.spec_result, req.big_sign, req.eff_sub, req.res_exp,
                     req.big_man, req.small_aln, req.spec_valid, req.spec_result);
        end
    endtask

    task automatic apply(input vec_t v);
        a_sign = v.a_sign; b_sign = v.b_sign; a_exp = v.a_exp; b_exp = v.b_exp;
        a_man = v.a_man; b_man = v.b_man; diff = v.diff; a_bigger = v.a_bigger;
        exp_cur = v.res;
    endtask

    // Drive one vector and hold it until the DUT accepts it.
    task automatic send(input vec_t v);
        int n = 0;
        apply(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding expected 0", sb.size());
        end
    endtask

    // Scoreboard: sample mid-cycle, predict the transfers at the coming edge.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: out_valid=1 with no pending result expected none");
                end else begin
                    check_data("sb_result", actual(), sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0,0,127,127,24'h800000,24'h800000,  0,1, 0,0,127,24'h800000,27'h4000000,0,32'h0);
        vecs[1]  = mk(0,1,127,127,24'h800000,24'hC00000,  0,1, 1,1,127,24'hC00000,27'h4000000,0,32'h0);
        vecs[2]  = mk(0,0,157,127,24'h800000,24'h800000, 30,1, 0,0,157,24'h800000,27'h0000001,0,32'h0);
        vecs[3]  = mk(0,0,255,  0,24'h800000,24'h800000,255,1, 0,0,255,24'h800000,27'h0000001,1,32'h7F800000);
        vecs[4]  = mk(0,0,  1,  0,24'h800000,24'h400000,  1,1, 0,0,  1,24'h800000,27'h2000000,0,32'h0);
        vecs[5]  = mk(0,1,255,255,24'h800000,24'h800000,  0,1, 0,1,255,24'h800000,27'h4000000,1,32'h7FC00000);
        vecs[6]  = mk(0,0,255,127,24'h800000,24'h800000,128,1, 0,0,255,24'h800000,27'h0000001,1,32'h7F800000);
        vecs[7]  = mk(0,0,127,255,24'h800000,24'hC00000,128,0, 0,0,255,24'hC00000,27'h0000001,1,32'h7FC00000);
        vecs[8]  = mk(1,0,131,127,24'h800000,24'h800003,  4,1, 1,1,131,24'h800000,27'h0400001,0,32'h0);
        vecs[9]  = mk(0,0,  0,  0,24'h000000,24'h000000,  0,1, 0,0,  1,24'h000000,27'h0000000,0,32'h0);
        vecs[10] = mk(0,1,  0,  0,24'h100000,24'h200000,  0,1, 1,1,  1,24'h200000,27'h0800000,0,32'h0);
        vecs[11] = mk(0,0,100,102,24'h800000,24'h900000,  2,0, 0,0,102,24'h900000,27'h1000000,0,32'h0);
        vecs[12] = mk(0,1,127,255,24'h800000,24'h800000,128,0, 1,1,255,24'h800000,27'h0000001,1,32'hFF800000);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_data("rst_data", actual(), '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // One-cycle latency, then out_valid falls with no new input
        out_ready = 1'b1;
        apply(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_bit("latency_valid", out_valid, 1'b1);
        check_data("latency_data", actual(), vecs[0].res);
        @(posedge clk);
        #1;
        check_bit("valid_falls", out_valid, 1'b0);

        // Table streamed back to back through the scoreboard
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain();

        // Backpressure: hold for 3 cycles, next input must wait, not vanish
        out_ready = 1'b0;
        send(vecs[2]);
        apply(vecs[8]);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_bit("hold_in_ready", in_ready, 1'b0);
            check_bit("hold_valid", out_valid, 1'b1);
            check_data("hold_data", actual(), vecs[2].res);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_data("after_hold_data", actual(), vecs[8].res);
        drain();

        // Async reset in the middle of a hold
        out_ready = 1'b0;
        send(vecs[1]);
        #1;
        rst = 1'b1;
        #1;
        check_bit("midhold_rst_valid", out_valid, 1'b0);
        check_data("midhold_rst_data", actual(), '0);
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;

        // Flush with a concurrent input drops it
        out_ready = 1'b1;
        apply(vecs[4]);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_bit("flush_drop_valid", out_valid, 1'b0);

        // Flush while a result is held
        out_ready = 1'b0;
        send(vecs[5]);
        check_bit("pre_flush_valid", out_valid, 1'b1);
        apply(vecs[4]);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check_bit("flush_held_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_bit("flush_stays_empty", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
